pipe_elastic_reg: RTL and testbench

//  Parametrised elastic pipeline register: a DEPTH-entry buffer of WIDTH-bit words with

---
 rtl/pipe_elastic_reg_pkg.sv | 13 +
 rtl/pipe_elastic_reg_wrap_ctr.sv | 25 ++
 rtl/pipe_elastic_reg.sv | 85 ++++++++
 tb/tb_pipe_elastic_reg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_elastic_reg_pkg.sv
// Width helpers shared by the elastic pipeline register and its pointer counters.
package pipe_elastic_reg_pkg;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A single-entry buffer still needs a 1-bit pointer so port and signal widths stay legal.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipe_elastic_reg_wrap_ctr.sv
// Modulo-DEPTH pointer counter with synchronous clear; wraps DEPTH-1 -> 0 by explicit compare.
module wrap_ctr #(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == LAST) ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: DEPTH-entry FIFO with valid/ready on both sides, flush and occupancy.
module pipe_elastic_reg
   import pipe_elastic_reg_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic                         i_clk,
   input  logic                         i_rstn,
   input  logic [WIDTH-1:0]             i_d,
   input  logic                         i_valid,
   output logic                         o_ready,
   output logic [WIDTH-1:0]             o_q,
   output logic                         o_valid,
   input  logic                         i_ready,
   input  logic                         i_flush,
   output logic [cnt_width(DEPTH)-1:0]  o_count
);

   localparam int               CNT_W = cnt_width(DEPTH);
   localparam int               PTR_W = ptr_width(DEPTH);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Ready depends on occupancy only, so downstream i_ready never reaches o_ready.
   assign o_ready = (count < FULL);
   assign o_valid = (count != '0);
   assign o_q     = mem[rd_ptr];
   assign o_count = count;
   assign push    = i_valid & o_ready;
   assign pop     = o_valid & i_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         count <= '0;
      end else if (i_flush) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + CNT_W'(1);
      end else if (pop && !push) begin
         count <= count - CNT_W'(1);
      end
   end

   // Flush leaves storage untouched; it only suppresses the write that cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else if (push && !i_flush) begin
         mem[wr_ptr] <= i_d;
      end
   end

   wrap_ctr #(
      .DEPTH (DEPTH),
      .W     (PTR_W)
   ) u_wr_ctr (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .clr    (i_flush),
      .inc    (push),
      .q      (wr_ptr)
   );

   wrap_ctr #(
      .DEPTH (DEPTH),
      .W     (PTR_W)
   ) u_rd_ctr (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .clr    (i_flush),
      .inc    (pop),
      .q      (rd_ptr)
   );

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg: DEPTH=2 handshake/flush/reset vectors, DEPTH=3 queue-model wrap run.
module tb_pipe_elastic_reg;

   logic        i_clk;
   logic        a_rstn, a_valid, a_ready, a_flush;
   logic [31:0] a_d;
   logic        a_o_ready, a_o_valid;
   logic [31:0] a_o_q;
   logic [1:0]  a_o_count;

   logic        b_rstn, b_valid, b_ready, b_flush;
   logic [31:0] b_d;
   logic        b_o_ready, b_o_valid;
   logic [31:0] b_o_q;
   logic [1:0]  b_o_count;

   int num_checks   = 0;
   int num_failures = 0;

   logic [31:0] model_q[$];

   pipe_elastic_reg #(
      .WIDTH       (32),
      .DEPTH       (2),
      .RESET_VALUE (32'hDEAD_BEEF)
   ) dut_a (
      .i_clk   (i_clk),
      .i_rstn  (a_rstn),
      .i_d     (a_d),
      .i_valid (a_valid),
      .o_ready (a_o_ready),
      .o_q     (a_o_q),
      .o_valid (a_o_valid),
      .i_ready (a_ready),
      .i_flush (a_flush),
      .o_count (a_o_count)
   );

   pipe_elastic_reg #(
      .WIDTH       (32),
      .DEPTH       (3),
      .RESET_VALUE (32'h0000_0000)
   ) dut_b (
      .i_clk   (i_clk),
      .i_rstn  (b_rstn),
      .i_d     (b_d),
      .i_valid (b_valid),
      .o_ready (b_o_ready),
      .o_q     (b_o_q),
      .o_valid (b_o_valid),
      .i_ready (b_ready),
      .i_flush (b_flush),
      .o_count (b_o_count)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_failures++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rstn, input logic valid, input logic [31:0] d,
                                input logic ready, input logic flush);
      a_rstn  = rstn;
      a_valid = valid;
      a_d     = d;
      a_ready = ready;
      a_flush = flush;
      stepClock();
   endtask

   task automatic checkA(input string tag, input logic valid, input logic rdy, input logic [1:0] cnt);
      checkOutput({tag, ".valid"}, {31'b0, a_o_valid}, {31'b0, valid});
      checkOutput({tag, ".ready"}, {31'b0, a_o_ready}, {31'b0, rdy});
      checkOutput({tag, ".count"}, {30'b0, a_o_count}, {30'b0, cnt});
   endtask

   initial begin
      logic exp_push, exp_pop;

      b_rstn = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_flush = 1'b0; b_d = '0;

      // Reset held for two edges
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkA("reset", 1'b0, 1'b1, 2'd0);
      checkOutput("reset.q", a_o_q, 32'hDEAD_BEEF);
      b_rstn = 1'b1;

      // Fill with downstream stalled, third word held off
      applyStimulus(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
      checkA("fill1", 1'b1, 1'b1, 2'd1);
      checkOutput("fill1.q", a_o_q, 32'h11);
      applyStimulus(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
      checkA("fill2", 1'b1, 1'b0, 2'd2);
      applyStimulus(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
      checkA("hold", 1'b1, 1'b0, 2'd2);
      checkOutput("hold.q", a_o_q, 32'h11);
      applyStimulus(1'b1, 1'b1, 32'h33, 1'b1, 1'b0);
      checkA("drain1", 1'b1, 1'b1, 2'd1);
      checkOutput("drain1.q", a_o_q, 32'h22);
      applyStimulus(1'b1, 1'b1, 32'h33, 1'b1, 1'b0);
      checkA("drain2", 1'b1, 1'b1, 2'd1);
      checkOutput("drain2.q", a_o_q, 32'h33);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkA("drain3", 1'b0, 1'b1, 2'd0);

      // Streaming: one word in flight, output = input delayed one cycle
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i), 1'b1, 1'b0);
         checkOutput($sformatf("stream%0d.count", i), {30'b0, a_o_count}, 32'd1);
         checkOutput($sformatf("stream%0d.q", i), a_o_q, 32'(i));
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkA("stream_end", 1'b0, 1'b1, 2'd0);

      // Flush with simultaneous push
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
      checkA("preflush", 1'b1, 1'b1, 2'd1);
      applyStimulus(1'b1, 1'b1, 32'h44, 1'b0, 1'b1);
      checkA("flush", 1'b0, 1'b1, 2'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkA("postflush", 1'b0, 1'b1, 2'd0);
      applyStimulus(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
      checkA("after_flush", 1'b1, 1'b1, 2'd1);
      checkOutput("after_flush.q", a_o_q, 32'h55);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkA("after_flush_drain", 1'b0, 1'b1, 2'd0);

      // Reset mid-operation discards buffered words
      applyStimulus(1'b1, 1'b1, 32'h66, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
      checkA("prereset", 1'b1, 1'b0, 2'd2);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkA("midreset", 1'b0, 1'b1, 2'd0);
      checkOutput("midreset.q", a_o_q, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkA("postreset", 1'b0, 1'b1, 2'd0);
      applyStimulus(1'b1, 1'b1, 32'h88, 1'b0, 1'b0);
      checkA("postreset_push", 1'b1, 1'b1, 2'd1);
      checkOutput("postreset_push.q", a_o_q, 32'h88);

      // DEPTH=3 random push/pop against a queue model
      for (int i = 0; i < 60; i++) begin
         checkOutput($sformatf("wrap%0d.count", i), {30'b0, b_o_count}, 32'(model_q.size()));
         checkOutput($sformatf("wrap%0d.valid", i), {31'b0, b_o_valid}, {31'b0, (model_q.size() != 0)});
         checkOutput($sformatf("wrap%0d.ready", i), {31'b0, b_o_ready}, {31'b0, (model_q.size() < 3)});
         if (model_q.size() != 0) begin
            checkOutput($sformatf("wrap%0d.q", i), b_o_q, model_q[0]);
         end
         b_valid = ($urandom_range(0, 3) != 0);
         b_ready = ($urandom_range(0, 1) != 0);
         b_d     = $urandom;
         exp_push = b_valid && (model_q.size() < 3);
         exp_pop  = b_ready && (model_q.size() != 0);
         stepClock();
         if (exp_pop) begin
            void'(model_q.pop_front());
         end
         if (exp_push) begin
            model_q.push_back(b_d);
         end
      end
      checkOutput("wrap_end.count", {30'b0, b_o_count}, 32'(model_q.size()));

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
      $finish;
   end

endmodule
